// File: rtl/pixel_frame_tx.sv
// Transmit side of the 16-bit pixel frame link: buffers NUM_PIX pixels, then sends sync/control/pixels.
// Optional checksum word after the pixels when PIXEL_FRAME_TX_CHKSUM_EN is defined.
module pixel_frame_tx #(
  parameter int          NUM_PIX   = 16,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        START,
  input  logic [15:0] CNTL_WORD,
  input  logic        S_VALID,
  input  logic [15:0] S_DATA,
  output logic        S_READY,
  output logic        TX_GO,
  output logic [15:0] DOUT,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CW = $clog2(NUM_PIX + 1);
  localparam int IW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIX - 1);

`ifdef PIXEL_FRAME_TX_CHKSUM_EN
  typedef enum logic [3:0] {
    sIDLE, sLOAD, sGO, sSYNC0, sSYNC1, sSYNC2, sCNTL, sPIX, sCSUM
  } state_t;
`else
  typedef enum logic [3:0] {
    sIDLE, sLOAD, sGO, sSYNC0, sSYNC1, sSYNC2, sCNTL, sPIX
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_idx_q, wr_idx_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]     cntl_q, cntl_d;
  logic [15:0]     pix_buf [NUM_PIX];
  logic [15:0]     dout_q, dout_d;
  logic            tx_go_q, tx_go_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            s_ready_q, s_ready_d;
  logic            accept;
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
  logic [15:0]     sum_q, sum_d;
`endif

  assign accept  = s_ready_q && S_VALID;
  assign S_READY = s_ready_q;
  assign TX_GO   = tx_go_q;
  assign DOUT    = dout_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= sIDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      cntl_q    <= '0;
      dout_q    <= IDLE_WORD;
      tx_go_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      cntl_q    <= cntl_d;
      dout_q    <= dout_d;
      tx_go_q   <= tx_go_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Pixel storage is not reset; its contents are only read after a full load.
  always_ff @(posedge CLK) begin
    if (accept) pix_buf[wr_idx_q[IW-1:0]] <= S_DATA;
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cntl_d   = cntl_q;
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      sIDLE: begin
        if (START) begin
          state_d  = sLOAD;
          cntl_d   = CNTL_WORD;
          wr_idx_d = '0;
          rd_idx_d = '0;
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
          sum_d    = '0;
`endif
        end
      end
      sLOAD: begin
        if (accept) begin
          wr_idx_d = wr_idx_q + CW'(1);
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
          sum_d    = sum_q + S_DATA;
`endif
          if (wr_idx_q == LAST_IDX) state_d = sGO;
        end
      end
      sGO:    state_d = sSYNC0;
      sSYNC0: state_d = sSYNC1;
      sSYNC1: state_d = sSYNC2;
      sSYNC2: state_d = sCNTL;
      sCNTL:  state_d = sPIX;
      sPIX: begin
        if (rd_idx_q == LAST_IDX) begin
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
          state_d = sCSUM;
`else
          state_d = sIDLE;
`endif
        end else begin
          rd_idx_d = rd_idx_q + CW'(1);
        end
      end
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
      sCSUM:  state_d = sIDLE;
`endif
      default: state_d = sIDLE;
    endcase
  end

  // Link outputs trail the state by one register stage; ready/busy track the next state.
  always_comb begin
    dout_d    = IDLE_WORD;
    tx_go_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != sIDLE);
    s_ready_d = (state_d == sLOAD);
    case (state_q)
      sGO:    tx_go_d = 1'b1;
      sSYNC0: dout_d  = 16'hFFFF;
      sSYNC1: dout_d  = 16'hFFFF;
      sSYNC2: dout_d  = 16'hAAAA;
      sCNTL:  dout_d  = cntl_q;
      sPIX: begin
        dout_d = pix_buf[rd_idx_q[IW-1:0]];
`ifndef PIXEL_FRAME_TX_CHKSUM_EN
        done_d = (rd_idx_q == LAST_IDX);
`endif
      end
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
      sCSUM: begin
        dout_d = sum_q;
        done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Randomized self-checking bench for pixel_frame_tx against a frame-level reference model.
// Define PIXEL_FRAME_TX_CHKSUM_EN for both files to exercise the checksum build.
module tb_pixel_frame_tx;

  localparam int          NUM_PIX   = 16;
  localparam logic [15:0] IDLE_WORD = 16'h0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        START = 1'b0;
  logic [15:0] CNTL_WORD = '0;
  logic        S_VALID = 1'b0;
  logic [15:0] S_DATA = '0;
  logic        S_READY, TX_GO, BUSY, DONE;
  logic [15:0] DOUT;

  int tests = 0;
  int fails = 0;

  logic [15:0] pix [NUM_PIX];
  logic [15:0] fw [$];

  pixel_frame_tx #(.NUM_PIX(NUM_PIX), .IDLE_WORD(IDLE_WORD)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .CNTL_WORD(CNTL_WORD),
    .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY), .TX_GO(TX_GO),
    .DOUT(DOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, DOUT, IDLE_WORD);
    chk({tag, "_go"}, 16'(TX_GO), 16'h0);
    chk({tag, "_ready"}, 16'(S_READY), 16'h0);
    chk({tag, "_busy"}, 16'(BUSY), 16'h0);
    chk({tag, "_done"}, 16'(DONE), 16'h0);
  endtask

  // Modes: 0 all-valid counting pixels, 1 alternating valid, 2 random valid with START
  // held and CNTL_WORD churning, 3 random valid/pixels, 4 all-FFFF pixels.
  // Entered and left at a falling edge; the entry edge is the START cycle.
  task automatic run_frame(input logic [15:0] cntl, input int mode);
    int acc, cyc, load_cyc, last;
    logic [15:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      case (mode)
        0, 1:    pix[i] = 16'(i + 1);
        4:       pix[i] = 16'hFFFF;
        default: pix[i] = 16'($urandom);
      endcase
    end
    if (mode == 2 || mode == 3) begin
      pix[1] = 16'hFFFF;
      pix[2] = 16'hAAAA;
    end
    fw.delete();
    fw.push_back(IDLE_WORD);
    fw.push_back(16'hFFFF);
    fw.push_back(16'hFFFF);
    fw.push_back(16'hAAAA);
    fw.push_back(cntl);
    for (int i = 0; i < NUM_PIX; i++) begin
      fw.push_back(pix[i]);
      sum = sum + pix[i];
    end
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
    fw.push_back(sum);
`endif
    last = fw.size() - 1;

    START = 1'b1;
    CNTL_WORD = cntl;
    S_VALID = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < NUM_PIX && cyc < 500) begin
      @(negedge CLK);
      cyc++;
      chk("load_ready", 16'(S_READY), 16'h1);
      chk("load_go", 16'(TX_GO), 16'h0);
      chk("load_dout", DOUT, IDLE_WORD);
      chk("load_busy", 16'(BUSY), 16'h1);
      START = (mode == 2);
      if (mode == 2) CNTL_WORD = 16'($urandom);
      case (mode)
        0, 4:    S_VALID = 1'b1;
        1:       S_VALID = (cyc % 2 == 0);
        default: S_VALID = 1'($urandom_range(0, 1));
      endcase
      S_DATA = S_VALID ? pix[acc] : 16'($urandom);
      if (S_VALID) acc++;
    end
    if (acc < NUM_PIX) begin
      chk("load_timeout", 16'(acc), 16'(NUM_PIX));
      START = 1'b0;
      S_VALID = 1'b0;
      return;
    end
    load_cyc = cyc;
    if (mode == 1) chk("stall_ready_cycles", 16'(load_cyc), 16'(2 * NUM_PIX));

    @(negedge CLK);
    cyc++;
    chk("gap_ready", 16'(S_READY), 16'h0);
    chk("gap_go", 16'(TX_GO), 16'h0);
    chk("gap_dout", DOUT, IDLE_WORD);
    S_VALID = 1'($urandom_range(0, 1));
    S_DATA = 16'($urandom);

    for (int i = 0; i <= last; i++) begin
      @(negedge CLK);
      cyc++;
      if (i == 0 && mode == 0) chk("start_latency", 16'(cyc), 16'(NUM_PIX + 2));
      chk("frame_dout", DOUT, fw[i]);
      chk("frame_go", 16'(TX_GO), 16'(i == 0));
      chk("frame_done", 16'(DONE), 16'(i == last));
      chk("frame_busy", 16'(BUSY), 16'(i < last));
      chk("frame_ready", 16'(S_READY), 16'h0);
      START = (mode == 2) && (i < last);
      S_VALID = 1'($urandom_range(0, 1));
      S_DATA = 16'($urandom);
    end
    START = 1'b0;
    S_VALID = 1'b0;
    if (mode == 4) begin
`ifdef PIXEL_FRAME_TX_CHKSUM_EN
      chk("chksum_ffff", DOUT, 16'(NUM_PIX * 16'hFFFF));
`else
      chk("last_pix_ffff", DOUT, 16'hFFFF);
`endif
    end
  endtask

  initial begin
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk_idle("rst_hold");
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk_idle("rst_release");

    run_frame(16'h1234, 0);
    @(negedge CLK);
    chk_idle("post_basic");

    run_frame(16'h5A5A, 1);
    @(negedge CLK);
    chk_idle("post_stall");

    run_frame(16'(($urandom)), 2);
    @(negedge CLK);
    chk_idle("post_ignore");

    run_frame(16'($urandom), 3);
    run_frame(16'($urandom), 3);
    @(negedge CLK);
    chk_idle("post_b2b");

    START = 1'b1;
    CNTL_WORD = 16'hBEEF;
    for (int k = 1; k <= NUM_PIX + 9; k++) begin
      @(negedge CLK);
      START = 1'b0;
      S_VALID = 1'b1;
      S_DATA = 16'($urandom);
    end
    S_VALID = 1'b0;
    nRST = 1'b0;
    #1;
    chk_idle("rst_midframe");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk_idle("rst_mid_release");
    run_frame(16'h4321, 0);
    @(negedge CLK);
    chk_idle("post_reset_frame");

    run_frame(16'h0F0F, 4);
    @(negedge CLK);
    chk_idle("post_ffff");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
